// File: rtl/ram_dump_reader_if.sv
// Bundle for the RAM dump reader: host control, RAM read port and byte stream.
// The slave modport is the reader; the master modport is the host/RAM side.
interface ram_dump_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, first_addr, last_addr,
    input  ram_rdata, out_ready,
    output ram_rd_en, ram_addr,
    output out_valid, out_data, out_addr,
    output busy, done
  );

  modport master (
    output start, first_addr, last_addr,
    output ram_rdata, out_ready,
    input  ram_rd_en, ram_addr,
    input  out_valid, out_data, out_addr,
    input  busy, done
  );
endinterface

// File: rtl/ram_dump_reader.sv
// Walks an inclusive, wrapping address range of the RAM read port and
// streams each byte with its address over a valid/ready interface.
module ram_dump_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic               fastClk,
  input  logic               rst,
  ram_dump_reader_if.slave   bus
);
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    PRESENT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] span;

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      raddr_q <= '0;
      oaddr_q <= '0;
      odata_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      raddr_q <= raddr_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      rem_q   <= rem_d;
    end
  end

  // span is (last - first) mod 2^ADDR_WIDTH, so a full wrap yields 2^ADDR_WIDTH bytes
  assign span = bus.last_addr - bus.first_addr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    raddr_d = raddr_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ptr_d   = bus.first_addr;
          rem_d   = {1'b0, span} + CW'(1);
          state_d = READ;
        end
      end
      READ: begin
        raddr_d = ptr_q;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        odata_d = bus.ram_rdata;
        oaddr_d = ptr_q;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.out_ready) begin
          if (rem_q == CW'(1)) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_rd_en = (state_q == READ);
    bus.ram_addr  = (state_q == READ) ? ptr_q : raddr_q;
    bus.out_valid = (state_q == PRESENT);
    bus.out_data  = odata_q;
    bus.out_addr  = oaddr_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
  end
endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader: table vectors, directed
// corner sequences and random dumps against a queue-based model.
module tb_ram_dump_reader;
  logic fastClk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem [16];
  int passed = 0;
  int total = 0;

  ram_dump_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  ram_dump_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .fastClk (fastClk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 fastClk = ~fastClk;

  // RAM model: data appears one cycle after the read strobe
  always @(posedge fastClk)
    if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr];

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    int         n;
    int         done_c;
  } vec_t;

  // rmode: 0 = ready always high, 1 = random ready
  task automatic do_dump(input string tag, input logic [3:0] f,
                         input logic [3:0] l, input int rmode,
                         input int stall_n, input bit poke,
                         input int exp_done_c);
    logic [3:0] ea[$];
    logic [7:0] ed[$];
    logic [3:0] ga[$];
    logic [7:0] gd[$];
    logic [3:0] rd[$];
    int n, c, dones, done_c, stalled, rd_pre, bad_hold, first_v;
    bit hold, got_done, rdy, fin;
    logic [7:0] hd;
    logic [3:0] ha;
    n = int'(4'(l - f)) + 1;
    for (int i = 0; i < n; i++) begin
      ea.push_back(4'(int'(f) + i));
      ed.push_back(mem[4'(int'(f) + i)]);
    end
    dones = 0; done_c = -1; stalled = 0; rd_pre = 0;
    bad_hold = 0; first_v = -1; hold = 0; got_done = 0;
    fin = 0; hd = '0; ha = '0;
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.out_ready  = 1'b0;
    bus.start      = 1'b1;
    @(posedge fastClk); #1;
    bus.start = 1'b0;
    c = 1;
    while (c < 400 && !fin) begin
      if (bus.ram_rd_en) begin
        rd.push_back(bus.ram_addr);
        if (ga.size() == 0) rd_pre++;
      end
      if (hold && !(bus.out_valid && bus.out_data == hd && bus.out_addr == ha))
        bad_hold++;
      if (bus.out_valid && first_v < 0) first_v = c;
      if (bus.done) begin
        dones++;
        if (!got_done) done_c = c;
        got_done = 1;
      end else if (got_done) begin
        fin = 1;
      end
      if (!fin) begin
        rdy = (rmode == 0) ? 1'b1 : (($urandom % 3) != 0);
        if (bus.out_valid && stalled < stall_n) begin
          rdy = 1'b0;
          stalled++;
        end
        bus.out_ready = rdy;
        bus.start = poke && bus.out_valid;
        if (poke) begin
          bus.first_addr = 4'($urandom);
          bus.last_addr  = 4'($urandom);
        end
        if (bus.out_valid && rdy) begin
          ga.push_back(bus.out_addr);
          gd.push_back(bus.out_data);
        end
        hold = bus.out_valid && !rdy;
        hd = bus.out_data;
        ha = bus.out_addr;
        @(posedge fastClk); #1;
        c++;
      end
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, " done_seen"}, int'(got_done), 1);
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " busy_after"}, int'(bus.busy), 0);
    chk({tag, " xfer_count"}, ga.size(), n);
    chk({tag, " read_count"}, rd.size(), n);
    chk({tag, " stable_stall"}, bad_hold, 0);
    for (int i = 0; i < n && i < ga.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), int'(ga[i]), int'(ea[i]));
      chk($sformatf("%s data[%0d]", tag, i), int'(gd[i]), int'(ed[i]));
    end
    for (int i = 0; i < n && i < rd.size(); i++)
      chk($sformatf("%s rdaddr[%0d]", tag, i), int'(rd[i]), int'(ea[i]));
    if (exp_done_c > 0) begin
      chk({tag, " done_cycle"}, done_c, exp_done_c);
      chk({tag, " first_valid"}, first_v, 3);
    end
    if (stall_n > 0) chk({tag, " reads_before_1st"}, rd_pre, 1);
  endtask

  vec_t vt [6];

  initial begin
    vt[0] = '{f: 4'd0,  l: 4'd15, n: 16, done_c: 49};
    vt[1] = '{f: 4'd5,  l: 4'd5,  n: 1,  done_c: 4};
    vt[2] = '{f: 4'd9,  l: 4'd8,  n: 16, done_c: 49};
    vt[3] = '{f: 4'd7,  l: 4'd10, n: 4,  done_c: 13};
    vt[4] = '{f: 4'd15, l: 4'd0,  n: 2,  done_c: 7};
    vt[5] = '{f: 4'd3,  l: 4'd3,  n: 1,  done_c: 4};

    bus.start = 0; bus.first_addr = 0; bus.last_addr = 0;
    bus.out_ready = 0; bus.ram_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    repeat (3) @(posedge fastClk);
    #1;
    chk("rst busy", int'(bus.busy), 0);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst rd_en", int'(bus.ram_rd_en), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst ram_addr", int'(bus.ram_addr), 0);
    chk("rst out_data", int'(bus.out_data), 0);
    rst = 0;
    @(posedge fastClk); #1;

    for (int k = 0; k < 6; k++) begin
      chk($sformatf("vec%0d size", k), int'(4'(vt[k].l - vt[k].f)) + 1, vt[k].n);
      do_dump($sformatf("vec%0d", k), vt[k].f, vt[k].l, 0, 0, 0, vt[k].done_c);
    end

    mem[5] = 8'hA7;
    do_dump("single", 4'd5, 4'd5, 0, 0, 0, 4);

    mem[14] = 8'hE0; mem[15] = 8'hF0; mem[0] = 8'h01; mem[1] = 8'h11;
    do_dump("wrap", 4'd14, 4'd1, 0, 0, 0, 13);

    mem[2] = 8'h22; mem[3] = 8'h33;
    do_dump("stall", 4'd2, 4'd3, 0, 7, 0, 0);

    do_dump("busy_start", 4'd14, 4'd2, 0, 0, 1, 16);

    // reset during the third byte's PRESENT
    begin
      int vcount, guard;
      bit pv;
      vcount = 0; guard = 0; pv = 0;
      bus.first_addr = 0; bus.last_addr = 15; bus.start = 1;
      bus.out_ready = 1;
      @(posedge fastClk); #1;
      bus.start = 0;
      while (vcount < 3 && guard < 100) begin
        if (bus.out_valid && !pv) vcount++;
        pv = bus.out_valid;
        if (vcount < 3) begin
          @(posedge fastClk); #1;
          guard++;
        end
      end
      chk("rst_mid reached", vcount, 3);
      bus.out_ready = 0;
      rst = 1;
      @(posedge fastClk); #1;
      rst = 0;
      chk("rst_mid out_valid", int'(bus.out_valid), 0);
      chk("rst_mid busy", int'(bus.busy), 0);
      chk("rst_mid done", int'(bus.done), 0);
      chk("rst_mid out_data", int'(bus.out_data), 0);
      chk("rst_mid out_addr", int'(bus.out_addr), 0);
      mem[0] = 8'h5C;
      do_dump("after_rst", 4'd0, 4'd0, 0, 0, 0, 4);
    end

    for (int r = 0; r < 25; r++) begin
      logic [3:0] rf, rl;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      rf = 4'($urandom);
      rl = 4'($urandom);
      do_dump($sformatf("rand%0d", r), rf, rl, 1, int'($urandom % 4),
              bit'($urandom % 2), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
